// File: rtl/pipeline_stage_regs_pkg.sv
// Shared constants and types for the PC / IF-ID / ID-EX register slice.
//   CTRL_W        width of the packed decode control bundle
//   CTRL_*        bit positions inside the control bundle
//   ctrlT         struct view of the control bundle
//   NOP_INSTR     instruction word placed in decode on a flush
//   RESET_PC_DEF  default PC after reset
package pipeline_stage_regs_pkg;

   localparam int unsigned CTRL_W  = 8;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned REG_W   = 5;

   // {RegWrite, MemtoReg[1:0], MemWrite, ALUControl[2:0], ALUSrc}
   localparam int unsigned CTRL_REGWRITE    = 7;
   localparam int unsigned CTRL_MEMTOREG_HI = 6;
   localparam int unsigned CTRL_MEMTOREG_LO = 5;
   localparam int unsigned CTRL_MEMWRITE    = 4;
   localparam int unsigned CTRL_ALUCTRL_HI  = 3;
   localparam int unsigned CTRL_ALUCTRL_LO  = 1;
   localparam int unsigned CTRL_ALUSRC      = 0;

   typedef struct packed {
      logic       regWrite;
      logic [1:0] memtoReg;
      logic       memWrite;
      logic [2:0] aluControl;
      logic       aluSrc;
   } ctrlT;

   localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;
   localparam logic [31:0]        RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pipeline_stage_regs_pipe_reg.sv
// Generic pipeline register with enable and synchronous clear.
//   clk, reset  clock and asynchronous active-high reset (clears q)
//   en          load enable; when low q holds (clear is ignored too)
//   clr         when enabled, load zero instead of d
//   d, q        data in / registered data out
module pipe_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    q <= '0;
      else if (en)  q <= clr ? '0 : d;
   end

endmodule

// File: rtl/pipeline_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers for the 5-stage core, driven by the
// hazard unit (StallF/StallD/FlushE) and the decode-stage branch (PCSrcD).
// Also counts stall cycles and inserted flushes/bubbles (saturating).
//   Inputs : clk, reset, StallF, StallD, FlushE, PCSrcD, PCBranchD, InstrF,
//            CtrlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD
//   Outputs: PCF, InstrD, PCPlus4D, ValidD, CtrlE, RD1E, RD2E, RsE, RtE,
//            RdE, SignImmE, ValidE, StallCount, FlushCount
module pipeline_stage_regs #(
   parameter int unsigned    WIDTH    = 32,
   parameter int unsigned    CTRL_W   = pipeline_stage_regs_pkg::CTRL_W,
   parameter int unsigned    CNT_W    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(pipeline_stage_regs_pkg::RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              StallF,
   input  logic              StallD,
   input  logic              FlushE,
   input  logic              PCSrcD,
   input  logic [WIDTH-1:0]  PCBranchD,
   input  logic [31:0]       InstrF,
   input  logic [CTRL_W-1:0] CtrlD,
   input  logic [WIDTH-1:0]  RD1D,
   input  logic [WIDTH-1:0]  RD2D,
   input  logic [4:0]        RsD,
   input  logic [4:0]        RtD,
   input  logic [4:0]        RdD,
   input  logic [WIDTH-1:0]  SignImmD,
   output logic [WIDTH-1:0]  PCF,
   output logic [31:0]       InstrD,
   output logic [WIDTH-1:0]  PCPlus4D,
   output logic              ValidD,
   output logic [CTRL_W-1:0] CtrlE,
   output logic [WIDTH-1:0]  RD1E,
   output logic [WIDTH-1:0]  RD2E,
   output logic [4:0]        RsE,
   output logic [4:0]        RtE,
   output logic [4:0]        RdE,
   output logic [WIDTH-1:0]  SignImmE,
   output logic              ValidE,
   output logic [CNT_W-1:0]  StallCount,
   output logic [CNT_W-1:0]  FlushCount
);
   import pipeline_stage_regs_pkg::*;

   localparam int unsigned IFID_W = 1 + WIDTH + INSTR_W;
   localparam int unsigned IDEX_W = 1 + CTRL_W + 3 * WIDTH + 3 * REG_W;

   logic [WIDTH-1:0]  pcPlus4F;
   logic              flushD;
   logic [IFID_W-1:0] ifidD, ifidQ;
   logic [IDEX_W-1:0] idexD, idexQ;
   logic [1:0]        flushInc;
   logic [CNT_W:0]    flushSum;

   // PC+4 wraps modulo 2^WIDTH
   assign pcPlus4F = PCF + WIDTH'(4);

   // Fetch PC
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        PCF <= RESET_PC;
      else if (!StallF) PCF <= PCSrcD ? PCBranchD : pcPlus4F;
   end

   // IF/ID: a stall holds even a taken branch, since the branch may have
   // been resolved on stale operands; a cleared slot reads as NOP / invalid
   assign flushD = PCSrcD & ~StallD;
   assign ifidD  = {1'b1, pcPlus4F, InstrF};

   pipe_reg #(.W(IFID_W)) u_ifid (
      .clk   (clk),
      .reset (reset),
      .en    (~StallD),
      .clr   (flushD),
      .d     (ifidD),
      .q     (ifidQ)
   );

   assign {ValidD, PCPlus4D, InstrD} = ifidQ;

   // ID/EX never stalls; a flush zeroes the control bundle so the bubble
   // cannot write the register file or memory
   assign idexD = {ValidD, CtrlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD};

   pipe_reg #(.W(IDEX_W)) u_idex (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .clr   (FlushE),
      .d     (idexD),
      .q     (idexQ)
   );

   assign {ValidE, CtrlE, RD1E, RD2E, RsE, RtE, RdE, SignImmE} = idexQ;

   // Flush events this cycle: decode flush and/or execute bubble
   assign flushInc = 2'(flushD) + 2'(FlushE);
   assign flushSum = {1'b0, FlushCount} + (CNT_W + 1)'(flushInc);

   // Saturating performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallD && (StallCount != {CNT_W{1'b1}}))
            StallCount <= StallCount + CNT_W'(1);
         FlushCount <= flushSum[CNT_W] ? {CNT_W{1'b1}} : flushSum[CNT_W-1:0];
      end
   end

endmodule
